enum_index_table_feeder: RTL
============================

# enum_index_table_feeder

Upstream stage for the `__enum_index__main` combinational lookup. Loads a 4-entry × 32-bit table from a word stream and presents it flattened on `arr`. Then issues enum selector values to the lookup stage through a registered valid/ready slot. Flags selectors whose `sel + 1` index falls outside the table, because the lookup stage clamps that index silently.

## Interface

Parameters:
- `WORD_W`, default 32: entry width. `arr` is `4*WORD_W` bits wide, and the lookup stage requires 32.

Ports:
- `clk`, in, 1: clock. One clock domain; everything updates on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `wr_valid`, in, 1: table word offered.
- `wr_ready`, out, 1: table word accepted when `wr_valid && wr_ready`.
- `wr_data`, in, WORD_W: table word.
- `clear`, in, 1: request to discard the table and reload it.
- `req_valid`, in, 1: selector request offered.
- `req_ready`, out, 1: selector request accepted when `req_valid && req_ready`.
- `req_sel`, in, 2: requested enum value.
- `arr`, out, 4*WORD_W: flattened table. Entry k occupies `arr[WORD_W*k +: WORD_W]`.
- `table_valid`, out, 1: the table is complete and `arr` is stable.
- `sel`, out, 2: selector driven to the lookup stage.
- `sel_valid`, out, 1: `sel` holds an unconsumed request.
- `sel_ready`, in, 1: the downstream consumer takes `sel`.
- `sel_oob`, out, 1: qualifies `sel`. Set when `sel == 3`, because the lookup index is then 4 and out of bounds (the lookup clamps it to entry 3).

## Operation

State machine with two states, FILL and ACTIVE.

FILL:
- `wr_ready = 1`, `req_ready = 0`, `table_valid = 0`.
- Each accepted word is written to entry `wr_ptr`, then the 2-bit `wr_ptr` increments.
- Accepting the word while `wr_ptr == 3` moves the block to ACTIVE on the next cycle, with `wr_ptr` wrapping to 0.
- `clear` in FILL resets `wr_ptr` to 0. Entries already written are kept, and the next writes overwrite them.
- If `clear` and a write occur in the same cycle, `clear` wins and the write is dropped. `wr_ready` stays 1, so the producer sees the word as accepted.

ACTIVE:
- `wr_ready = 0` and `table_valid = 1`. `arr` does not change.
- The output slot is a single register. `req_ready = !sel_valid || sel_ready`.
- An accepted request loads `sel <= req_sel`, `sel_oob <= (req_sel == 2'd3)` and `sel_valid <= 1`.
- A cycle with `sel_valid && sel_ready` and no new accept clears `sel_valid`. Accept and consume in the same cycle keeps `sel_valid = 1` with the new value (full throughput).

`clear` in ACTIVE:
- `clear` is honoured only when the slot is empty, or is being consumed in that cycle, and no new request is accepted.
- While `clear` is high in ACTIVE, `req_ready` is forced to 0, so the slot always drains first.
- On the honouring edge: state returns to FILL, `wr_ptr = 0`, all entries are zeroed, `sel_valid = 0`, `sel_oob = 0`.
- If the slot is full and `sel_ready = 0`, `clear` stalls. Hold `clear` until it takes effect.

Widths and indexing:
- `wr_ptr` is 2 bits and wraps naturally.
- There is no index arithmetic in this block. `sel_oob` is a pure decode of the registered `sel`.

## Timing

- Reset values: state FILL, `wr_ptr = 0`, `arr = 0`, `table_valid = 0`, `sel = 0`, `sel_valid = 0`, `sel_oob = 0`, `wr_ready = 1`, `req_ready = 0`.
- `wr_ready`, `req_ready` and `table_valid` are decoded from registered state only. They have no combinational path from `wr_valid`, `req_valid` or `clear`.
- Exception: in ACTIVE, `req_ready` combinationally depends on `sel_ready` and `clear`.
- Table load takes a minimum of 4 cycles. `table_valid` rises on the cycle after the 4th accepted word.
- Request-to-selector latency is 1 cycle: accept at edge N, `sel_valid`/`sel` are visible after edge N.
- Sustained throughput is 1 selector per cycle when `sel_ready = 1`.
- Reset mid-operation, in any state with a pending slot, returns every register to its reset value on that edge. The pending selector is lost.
- `rst` has priority over `clear`, writes and requests.

## Test plan

- Reset, then write 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles. Required: `arr = 0x44444444_33333333_22222222_11111111`, `table_valid` rises the cycle after the 4th word, and `wr_ready` falls with it.
- After the load, with `sel_ready = 1`, send `req_sel` 0,1,2,3 back-to-back. Required: `sel` is 0,1,2,3 each one cycle later, `sel_valid` stays high for 4 cycles, and `sel_oob = 1` only for 3.
- Hold `sel_ready = 0` with `req_sel = 1` accepted. Required: `req_ready = 0`, and a second request offered with `req_sel = 2` is not accepted. Release `sel_ready`: `sel` is 1 for that cycle, then 2 on the next cycle, with no loss.
- In ACTIVE, assert `clear` with the slot full and `sel_ready = 0` for 3 cycles, then `sel_ready = 1`. Required: state stays ACTIVE until the consume cycle. On the next edge `table_valid = 0`, `arr = 0` and `wr_ready = 1`.
- In FILL after 2 words, assert `clear` together with a `wr_valid` word. Required: the word is dropped. The next 4 writes load entries 0..3 in order.
- Assert `rst` for one cycle mid-stream, with `sel_valid = 1` and `table_valid = 1`. Required: every output equals its reset value on the following cycle.

Source files
------------

// File: rtl/enum_index_table_feeder.sv
// enum_index_table_feeder: loads a 4-entry table from a word stream, then
// feeds enum selectors to the combinational lookup stage through a single
// registered valid/ready slot, flagging selectors whose sel+1 index overflows.
module enum_index_table_feeder #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_sel,
  output logic [4*WORD_W-1:0]   arr,
  output logic                  table_valid,
  output logic [1:0]            sel,
  output logic                  sel_valid,
  input  logic                  sel_ready,
  output logic                  sel_oob
);

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned PTR_W   = 2;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
  localparam logic [1:0] OOB_SEL = 2'd3;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WORD_W-1:0] tbl [ENTRIES];

  logic slot_free;
  logic wr_take;
  logic req_take;
  logic clear_take;

  // Handshake strobes; clear always wins over a write in FILL and only lands
  // in ACTIVE once the slot is empty or draining.
  always_comb begin
    slot_free  = !sel_valid || sel_ready;
    wr_take    = (state == S_FILL) && wr_valid && !clear;
    req_take   = req_valid && req_ready;
    clear_take = (state == S_ACTIVE) && clear && slot_free;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // Next-state: the fourth accepted word arms the table, an honoured clear disarms it.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:   if (wr_take && (wr_ptr == LAST_PTR)) state_next = S_ACTIVE;
      S_ACTIVE: if (clear_take)                      state_next = S_FILL;
      default:  state_next = S_FILL;
    endcase
  end

  // Output decode from registered state; req_ready also sees sel_ready/clear.
  always_comb begin
    wr_ready    = 1'b0;
    req_ready   = 1'b0;
    table_valid = 1'b0;
    case (state)
      S_FILL:   wr_ready = 1'b1;
      S_ACTIVE: begin
        table_valid = 1'b1;
        req_ready   = slot_free && !clear;
      end
      default:  wr_ready = 1'b1;
    endcase
  end

  // Table storage and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (clear_take) begin
      wr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if ((state == S_FILL) && clear) begin
      wr_ptr <= '0;
    end else if (wr_take) begin
      tbl[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + PTR_W'(1);
    end
  end

  // Single-entry selector slot; accept-and-consume in one cycle keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      sel_valid <= 1'b0;
      sel_oob   <= 1'b0;
    end else if (clear_take) begin
      sel       <= '0;
      sel_valid <= 1'b0;
      sel_oob   <= 1'b0;
    end else if (req_take) begin
      sel       <= req_sel;
      sel_valid <= 1'b1;
      sel_oob   <= (req_sel == OOB_SEL);
    end else if (sel_valid && sel_ready) begin
      sel_valid <= 1'b0;
    end
  end

  // Flatten the table: entry k at arr[WORD_W*k +: WORD_W].
  for (genvar k = 0; k < ENTRIES; k++) begin : g_flat
    assign arr[WORD_W*k +: WORD_W] = tbl[k];
  end

endmodule
